// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: address/data/length types,
// the fetch FSM state encoding and the default 6502 reset vector location.
package fetch_unit_pkg;

  typedef logic [7:0]  data_t;
  typedef logic [15:0] addr_t;
  typedef logic [1:0]  len_t;

  typedef enum logic [2:0] {
    IDLE,
    VEC_LO,
    VEC_HI,
    OP,
    LO,
    HI,
    OUT
  } fetch_state_t;

  localparam addr_t RESET_VEC_DEFAULT = 16'hFFFC;

  localparam len_t LEN_1 = 2'd1;
  localparam len_t LEN_2 = 2'd2;
  localparam len_t LEN_3 = 2'd3;

endpackage

// File: rtl/fetch_unit_instr_length.sv
// Sizes a 6502 instruction (1-3 bytes) from its opcode byte alone,
// using the cc = op[1:0] / bbb = op[4:2] field split.
module fetch_unit_instr_length
  import fetch_unit_pkg::*;
(
  input  data_t opcode,
  output len_t  len
);

  logic [1:0] cc;
  logic [2:0] bbb;

  assign cc  = opcode[1:0];
  assign bbb = opcode[4:2];

  // Three-byte forms take priority so absolute modes with cc=11 stay 3 bytes.
  always_comb begin
    len = LEN_2;
    if ((opcode == 8'h20) || (bbb == 3'b011) || (bbb == 3'b111) ||
        ((cc == 2'b01) && (bbb == 3'b110))) begin
      len = LEN_3;
    end else if ((opcode == 8'h00) || (opcode == 8'h40) || (opcode == 8'h60) ||
                 (cc == 2'b11) ||
                 ((bbb == 3'b010) && !cc[0]) ||
                 ((bbb == 3'b110) && !cc[0]) ||
                 ((cc == 2'b10) && (bbb == 3'b100))) begin
      len = LEN_1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: loads the PC from the reset vector, then
// fetches opcode/operands and hands complete bundles to decode via valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  output logic  mem_req,
  output addr_t mem_addr,
  input  logic  mem_ack,
  input  data_t mem_rdata,
  output logic  instr_valid,
  input  logic  instr_ready,
  output data_t instr_opcode,
  output data_t instr_lo,
  output data_t instr_hi,
  output len_t  instr_len,
  output addr_t instr_pc,
  input  logic  redirect_valid,
  input  addr_t redirect_pc
);

  fetch_state_t state, state_next;
  addr_t        pc;
  len_t         op_len;
  logic         redirect_ok;

  fetch_unit_instr_length u_len (
    .opcode (mem_rdata),
    .len    (op_len)
  );

  assign redirect_ok = redirect_valid &&
                       ((state == OP) || (state == LO) ||
                        (state == HI) || (state == OUT));
  assign instr_valid = (state == OUT);

  // Next-state and memory request decode; a redirect overrides everything.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: state_next = VEC_LO;
      VEC_LO: begin
        mem_req  = 1'b1;
        mem_addr = RESET_VEC;
        if (mem_ack) state_next = VEC_HI;
      end
      VEC_HI: begin
        mem_req  = 1'b1;
        mem_addr = RESET_VEC + 16'd1;
        if (mem_ack) state_next = OP;
      end
      OP: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) state_next = (op_len == LEN_1) ? OUT : LO;
      end
      LO: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) state_next = (instr_len == LEN_2) ? OUT : HI;
      end
      HI: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) state_next = OUT;
      end
      OUT: if (instr_ready) state_next = OP;
      default: state_next = IDLE;
    endcase
    if (redirect_ok) state_next = OP;
  end

  // State, PC and bundle registers; ack data is dropped when a redirect lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      instr_opcode <= '0;
      instr_lo     <= '0;
      instr_hi     <= '0;
      instr_len    <= '0;
      instr_pc     <= '0;
    end else begin
      state <= state_next;
      if (redirect_ok) begin
        pc <= redirect_pc;
      end else begin
        case (state)
          VEC_LO: if (mem_ack) pc[7:0] <= mem_rdata;
          VEC_HI: if (mem_ack) pc[15:8] <= mem_rdata;
          OP: if (mem_ack) begin
            instr_opcode <= mem_rdata;
            instr_pc     <= pc;
            instr_len    <= op_len;
            instr_lo     <= '0;
            instr_hi     <= '0;
            pc           <= pc + 16'd1;
          end
          LO: if (mem_ack) begin
            instr_lo <= mem_rdata;
            pc       <= pc + 16'd1;
          end
          HI: if (mem_ack) begin
            instr_hi <= mem_rdata;
            pc       <= pc + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model with programmable wait states,
// and a scoreboard queue of expected bundles popped by an independent monitor.
module tb_fetch_unit;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  len;
    logic [15:0] pc;
  } bundle_t;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_lo;
  logic [7:0]  instr_hi;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [7:0] mem [0:65535];
  int         wait_cycles;
  int         wait_cnt;
  int         compared;
  int         mismatched;
  bundle_t    sb [$];

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_lo       (instr_lo),
    .instr_hi       (instr_hi),
    .instr_len      (instr_len),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers after wait_cycles unacked request cycles.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wait_cnt >= wait_cycles);

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout, required event within budget", name);
  endtask

  task automatic applyStimulus(input logic ready, input logic rv, input logic [15:0] rpc);
    instr_ready    = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake the DUT completes must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_bundle: got op %h pc %h, required no bundle",
                 instr_opcode, instr_pc);
      end else begin
        bundle_t exp_b;
        exp_b = sb.pop_front();
        checkOutput("bundle", 64'({instr_opcode, instr_lo, instr_hi, instr_len, instr_pc}),
                    64'(exp_b));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, required finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    bit found;
    compared    = 0;
    mismatched  = 0;
    wait_cycles = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hEA;
    mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h42;
    mem[16'h8003] = 8'hAD; mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
    mem[16'h8006] = 8'hE8;
    mem[16'h8007] = 8'h4C; mem[16'h8008] = 8'h00; mem[16'h8009] = 8'h90;
    mem[16'h800A] = 8'h20; mem[16'h800B] = 8'h55; mem[16'h800C] = 8'h66;
    mem[16'hC000] = 8'hEA;
    mem[16'hFFFF] = 8'hAD; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'h20; mem[16'h0003] = 8'h77; mem[16'h0004] = 8'h88;

    sb.push_back('{8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000});
    sb.push_back('{8'hA9, 8'h42, 8'h00, 2'd2, 16'h8001});
    sb.push_back('{8'hAD, 8'h34, 8'h12, 2'd3, 16'h8003});

    repeat (2) tick();
    checkOutput("reset_values", 64'({mem_req, mem_addr, instr_valid, instr_opcode,
                instr_lo, instr_hi, instr_len, instr_pc}), 64'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0000);

    // Vector load, then the first opcode request must come from 8000.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (mem_req && mem_addr != 16'hFFFC && mem_addr != 16'hFFFD) found = 1;
    end
    if (found) checkOutput("first_op_addr", 64'(mem_addr), 64'h8000);
    else timeoutFail("first_op_addr");

    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (instr_valid && instr_opcode == 8'hAD) found = 1;
    end
    if (!found) timeoutFail("wait_ad_bundle");

    // Backpressure on the single-byte E8 bundle.
    sb.push_back('{8'hE8, 8'h00, 8'h00, 2'd1, 16'h8006});
    tick();
    checkOutput("next_fetch_8006", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h8006}));
    applyStimulus(1'b0, 1'b0, 16'h0000);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("backpressure_hold", 64'({instr_valid, mem_req, instr_opcode, instr_lo,
                  instr_hi, instr_len, instr_pc}),
                  64'({1'b1, 1'b0, 8'hE8, 8'h00, 8'h00, 2'd1, 16'h8006}));
      tick();
    end

    // Three wait states per byte on 4C 00 90.
    wait_cycles = 3;
    sb.push_back('{8'h4C, 8'h00, 8'h90, 2'd3, 16'h8007});
    applyStimulus(1'b1, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 12; k++) begin
      logic [15:0] exp_addr;
      exp_addr = 16'h8007 + 16'(k / 4);
      checkOutput("wait_addr_hold", 64'({mem_req, instr_valid, mem_addr}),
                  64'({1'b1, 1'b0, exp_addr}));
      tick();
    end
    checkOutput("wait_bundle_valid", 64'(instr_valid), 64'h1);

    // Redirect during LO of JSR: partial fetch dropped, next request at C000.
    wait_cycles = 0;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput("jsr_lo_addr", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h800B}));
    applyStimulus(1'b1, 1'b1, 16'hC000);
    tick();
    checkOutput("redirect_c000", 64'({instr_valid, mem_req, mem_addr}),
                64'({1'b0, 1'b1, 16'hC000}));
    applyStimulus(1'b1, 1'b0, 16'h0000);

    // Redirect coinciding with a handshake: EA consumed, fetch moves to FFFF.
    sb.push_back('{8'hEA, 8'h00, 8'h00, 2'd1, 16'hC000});
    tick();
    checkOutput("c000_valid", 64'(instr_valid), 64'h1);
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    sb.push_back('{8'hAD, 8'h34, 8'h12, 2'd3, 16'hFFFF});
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("op_at_ffff", 64'({mem_req, mem_addr}), 64'({1'b1, 16'hFFFF}));
    tick();
    checkOutput("wrap_lo_addr", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h0000}));
    tick();
    checkOutput("wrap_hi_addr", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h0001}));
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      tick();
      if (instr_valid) found = 1;
    end
    if (!found) timeoutFail("wrap_bundle");
    applyStimulus(1'b1, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("pc_after_wrap", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h0002}));
    tick();
    tick();
    checkOutput("jsr_hi_addr", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h0004}));

    // Asynchronous reset in HI, then vector refetch after release.
    reset = 1'b1;
    #1;
    checkOutput("midop_reset", 64'({mem_req, mem_addr, instr_valid, instr_opcode,
                instr_lo, instr_hi, instr_len, instr_pc}), 64'h0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("idle_after_release", 64'({mem_req, mem_addr}), 64'h0);
    tick();
    checkOutput("vec_lo_refetch", 64'({mem_req, mem_addr}), 64'({1'b1, 16'hFFFC}));
    tick();
    checkOutput("vec_hi_refetch", 64'({mem_req, mem_addr}), 64'({1'b1, 16'hFFFD}));
    tick();
    checkOutput("op_after_refetch", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h8000}));
    repeat (3) tick();
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
